// File: rtl/fsm_trace_recorder_if.sv
// Read-side stream of the FSM trace recorder: one {in,out} sample per transfer.
interface fsm_trace_recorder_if #(
  parameter int DATA_W = 6
);
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;

  modport master (output rd_valid, rd_data, rd_last, input rd_ready);
  modport slave  (input rd_valid, rd_data, rd_last, output rd_ready);
endinterface

// File: rtl/fsm_trace_recorder.sv
// Captures {fsm_in,fsm_out} pairs of an observed Moore FSM, then streams them out.
// Optional FSM_TRACE_DEDUP_EN: skip samples identical to the previously stored one.
module fsm_trace_recorder #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 3,
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic [CNT_W:0]       len,
  input  logic [IN_W-1:0]      fsm_in,
  input  logic [OUT_W-1:0]     fsm_out,
  fsm_trace_recorder_if.master rd,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W:0]       count
);
  localparam int DW = IN_W + OUT_W;
  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W+1)'(DEPTH);
  localparam logic [CNT_W:0]   CNT_ONE = (CNT_W+1)'(1);
  localparam logic [CNT_W-1:0] PTR_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  state_t           state;
  logic [DW-1:0]    mem [DEPTH];
  logic [CNT_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W:0]   len_eff;
  logic [CNT_W:0]   count_nxt;
  logic             rd_valid_q;
  logic [DW-1:0]    sample;
  logic             wr_en;

  assign sample    = {fsm_in, fsm_out};
  assign count_nxt = count + CNT_ONE;

`ifdef FSM_TRACE_DEDUP_EN
  logic [DW-1:0] last_q;
  // First sample of a trace is always kept; later ones only if they differ.
  assign wr_en = (count == '0) || (sample != last_q);

  always_ff @(posedge clk)
    if (state == CAPTURE && wr_en) last_q <= sample;
`else
  assign wr_en = 1'b1;
`endif

  always_ff @(posedge clk)
    if (!reset && state == CAPTURE && wr_en) mem[wr_ptr] <= sample;

  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      len_eff    <= DEPTH_C;
      rd_valid_q <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          len_eff <= (len == '0 || len > DEPTH_C) ? DEPTH_C : len;
          count   <= '0;
          wr_ptr  <= '0;
          rd_ptr  <= '0;
          busy    <= 1'b1;
          state   <= CAPTURE;
        end
        CAPTURE: begin
          if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            count  <= count_nxt;
          end
          // len_eff <= DEPTH, so this also stops wr_ptr from wrapping.
          if (stop || (wr_en && count_nxt == len_eff)) begin
            rd_valid_q <= 1'b1;
            state      <= DRAIN;
          end
        end
        DRAIN: if (rd.rd_ready) begin
          rd_ptr <= rd_ptr + PTR_ONE;
          if (rd.rd_last) begin
            rd_valid_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs depend only on registered state, so they hold during a stall.
  assign rd.rd_valid = rd_valid_q;
  assign rd.rd_data  = rd_valid_q ? mem[rd_ptr] : '0;
  assign rd.rd_last  = rd_valid_q && ({1'b0, rd_ptr} == count - CNT_ONE);
endmodule
